phase_accumulator_bank: RTL and testbench

- Time-multiplexed, multi-voice phase accumulator: the next generation of the single-oscillator phase path.
- Holds a per-voice frequency-derived increment and a PHASE_INDEX_BITS phase register for each of VOICES voices.
- On each sample tick, sweeps all voices in order and streams each voice's phase to the wavetable lookup stage over a valid/ready handshake.
- Adds per-voice hard sync (phase reset), per-voice enable, and sweep-overrun detection.

---
 rtl/phase_accumulator_bank.sv | 123 ++++++++++++
 tb/tb_phase_accumulator_bank.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_accumulator_bank.sv
// phase_accumulator_bank: time-multiplexed multi-voice phase accumulator
// streaming per-voice phases to the wavetable stage over valid/ready.
module phase_accumulator_bank #(
  parameter int VOICES = 8,
  parameter int FREQUENCY_INTEGRAL_BITS = 15,
  parameter int FREQUENCY_FRACTIONAL_BITS = 7,
  parameter int WAVETABLE_N = 11,
  parameter int PHASE_INDEX_BITS = 48,
  parameter int C_BITS =
    PHASE_INDEX_BITS - FREQUENCY_FRACTIONAL_BITS - WAVETABLE_N,
  parameter longint unsigned C = 64'd45812984,
  localparam int VW = $clog2(VOICES),
  localparam int FW =
    FREQUENCY_INTEGRAL_BITS + FREQUENCY_FRACTIONAL_BITS,
  localparam int PW = PHASE_INDEX_BITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_tick,
  input  logic          freq_we,
  input  logic [VW-1:0] freq_voice,
  input  logic [FW-1:0] freq_value,
  input  logic          sync_we,
  input  logic [VW-1:0] sync_voice,
  input  logic [VOICES-1:0] voice_enable,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] out_voice,
  output logic [PW-1:0] out_phase,
  output logic          out_last,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [C_BITS-1:0] CK = C_BITS'(C);

  state_t state, state_d;

  logic [PW-1:0] phase [VOICES];
  logic [PW-1:0] inc   [VOICES];
  logic [VOICES-1:0] sync_pending;

  logic [PW-1:0] mul_inc;
  logic [VW-1:0] mul_voice;
  logic          mul_vld;

  logic [VW-1:0] v, v_nx;
  logic          out_sync;
  logic          hs, at_last;

  assign v_nx      = v + VW'(1);
  assign at_last   = (v == VW'(VOICES - 1));
  assign busy      = (state != IDLE);
  assign out_valid = (state == RUN);
  assign out_last  = out_valid & at_last;
  assign out_voice = v;
  assign hs        = out_valid & out_ready;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (sample_tick) state_d = RUN;
      RUN:  if (hs && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // out_sync snapshots the pending flag shown on out_phase so a sync
  // arriving mid-stall waits for the next sweep instead of tearing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
      end
      sync_pending <= '0;
      mul_inc      <= '0;
      mul_voice    <= '0;
      mul_vld      <= 1'b0;
      v            <= '0;
      out_phase    <= '0;
      out_sync     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      mul_vld   <= freq_we;
      mul_voice <= freq_voice;
      mul_inc   <= PW'(freq_value) * PW'(CK);
      if (mul_vld) inc[mul_voice] <= mul_inc;

      if (sample_tick && busy) overrun <= 1'b1;

      if (!busy && sample_tick) begin
        v         <= '0;
        out_phase <= sync_pending[0] ? '0 : phase[0];
        out_sync  <= sync_pending[0];
      end

      if (hs) begin
        if (out_sync) begin
          phase[v] <= voice_enable[v] ? inc[v] : '0;
          sync_pending[v] <= 1'b0;
        end else if (voice_enable[v]) begin
          phase[v] <= phase[v] + inc[v];
        end
        if (!at_last) begin
          v         <= v_nx;
          out_phase <= sync_pending[v_nx] ? '0 : phase[v_nx];
          out_sync  <= sync_pending[v_nx];
        end
      end

      if (sync_we) sync_pending[sync_voice] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_accumulator_bank.sv
// tb_phase_accumulator_bank: randomized sweeps checked against a
// sweep-level behavioural model of the voice bank.
module tb_phase_accumulator_bank;

  localparam int VOICES = 8;
  localparam int VW = 3;
  localparam int PW = 48;
  localparam longint unsigned CK = 64'd45812984;
  localparam longint unsigned MASK = (64'd1 << 48) - 64'd1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_tick = 1'b0;
  logic          freq_we = 1'b0;
  logic [VW-1:0] freq_voice = '0;
  logic [21:0]   freq_value = '0;
  logic          sync_we = 1'b0;
  logic [VW-1:0] sync_voice = '0;
  logic [VOICES-1:0] voice_enable = '1;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_voice;
  logic [PW-1:0] out_phase;
  logic          out_last;
  logic          busy;
  logic          overrun;

  phase_accumulator_bank dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .freq_we(freq_we), .freq_voice(freq_voice),
    .freq_value(freq_value), .sync_we(sync_we),
    .sync_voice(sync_voice), .voice_enable(voice_enable),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_voice(out_voice), .out_phase(out_phase),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  longint unsigned mphase [VOICES];
  longint unsigned minc   [VOICES];
  bit              msync  [VOICES];
  logic [PW-1:0]   last_out [VOICES];

  function automatic logic [PW-1:0] exp_out(int vi);
    return msync[vi] ? '0 : PW'(mphase[vi]);
  endfunction

  task automatic consume(int vi);
    if (msync[vi]) begin
      mphase[vi] = voice_enable[vi] ? minc[vi] : 64'd0;
      msync[vi] = 1'b0;
    end else if (voice_enable[vi]) begin
      mphase[vi] = (mphase[vi] + minc[vi]) & MASK;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < VOICES; i++) begin
      mphase[i] = 0;
      minc[i] = 0;
      msync[i] = 1'b0;
      last_out[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_tick = 1'b0;
    freq_we = 1'b0;
    sync_we = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic write_freq(int vi, longint unsigned f);
    @(negedge clk);
    freq_we = 1'b1;
    freq_voice = VW'(vi);
    freq_value = 22'(f);
    minc[vi] = (f * CK) & MASK;
    @(negedge clk);
    freq_we = 1'b0;
  endtask

  task automatic sync_pulse(int vi);
    @(negedge clk);
    sync_we = 1'b1;
    sync_voice = VW'(vi);
    msync[vi] = 1'b1;
    @(negedge clk);
    sync_we = 1'b0;
  endtask

  task automatic run_sweep(int stall_pct, bit stall5,
                           bit tick_mid, int sync_v);
    int got, cyc, st;
    bit r;
    @(negedge clk);
    sample_tick = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    sample_tick = 1'b0;
    got = 0; cyc = 0; st = 0;
    while (got < VOICES && cyc < 400) begin
      cyc++;
      tests++;
      if (out_valid !== 1'b1 || out_voice !== VW'(got) ||
          out_phase !== exp_out(got) ||
          out_last !== (got == VOICES - 1)) begin
        fails++;
        $display("FAIL sweep_out: valid=%b voice=%0d phase=%0d last=%b, required voice=%0d phase=%0d last=%0d",
                 out_valid, out_voice, out_phase, out_last,
                 got, exp_out(got), (got == VOICES - 1));
      end
      r = ($urandom_range(99) >= stall_pct);
      if (stall5 && got == 3 && st < 5) begin
        r = 1'b0;
        st++;
      end
      sample_tick = tick_mid && cyc == 4;
      sync_we = r && got == sync_v;
      sync_voice = VW'(sync_v >= 0 ? sync_v : 0);
      out_ready = r;
      if (r) begin
        last_out[got] = out_phase;
        consume(got);
        if (got == sync_v) msync[got] = 1'b1;
        got++;
      end
      @(negedge clk);
    end
    sample_tick = 1'b0;
    sync_we = 1'b0;
    out_ready = 1'b0;
    tests++;
    if (got != VOICES || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL sweep_end: outputs=%0d valid=%b busy=%b, required outputs=%0d valid=0 busy=0",
               got, out_valid, busy, VOICES);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
        overrun !== 1'b0 || out_voice !== '0 || out_phase !== '0) begin
      fails++;
      $display("FAIL reset_state: valid=%b last=%b busy=%b ovr=%b voice=%0d phase=%0d, required all 0",
               out_valid, out_last, busy, overrun, out_voice, out_phase);
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    do_reset();
    write_freq(0, 1);
    run_sweep(0, 0, 0, -1);
    tests++;
    if (last_out[0] !== 48'd0) begin
      fails++;
      $display("FAIL basic_first: got %0d, required 0", last_out[0]);
    end
    run_sweep(0, 0, 0, -1);
    tests++;
    if (last_out[0] !== 48'd45812984) begin
      fails++;
      $display("FAIL basic_second: got %0d, required 45812984",
               last_out[0]);
    end
  endtask

  task automatic test_440();
    do_reset();
    write_freq(3, 56320);
    run_sweep(0, 0, 0, -1);
    run_sweep(0, 0, 0, -1);
    tests++;
    if (last_out[3] !== 48'd2580187258880) begin
      fails++;
      $display("FAIL a440_inc: got %0d, required 2580187258880",
               last_out[3]);
    end
    run_sweep(0, 0, 0, -1);
    tests++;
    if (last_out[3] !== 48'd5160374517760 ||
        last_out[3][47:37] !== 11'd37) begin
      fails++;
      $display("FAIL a440_two: got %0d idx %0d, required 5160374517760 idx 37",
               last_out[3], last_out[3][47:37]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < VOICES; i++)
      write_freq(i, 64'd4194303 - 64'($urandom_range(4000)));
    for (int s = 0; s < 6; s++) run_sweep(20, 0, 0, -1);
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL wrap_no_flag: overrun=%b, required 0", overrun);
    end
  endtask

  task automatic test_stall_overrun();
    do_reset();
    for (int i = 0; i < VOICES; i++)
      write_freq(i, 64'($urandom_range(500000)));
    run_sweep(0, 0, 0, -1);
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
    end
    run_sweep(0, 1, 1, -1);
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: overrun=%b, required 1", overrun);
    end
    run_sweep(10, 0, 0, -1);
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
    end
  endtask

  task automatic test_sync();
    do_reset();
    write_freq(2, 1000);
    run_sweep(0, 0, 0, -1);
    run_sweep(0, 0, 0, -1);
    sync_pulse(2);
    sync_pulse(2);
    run_sweep(0, 0, 0, -1);
    tests++;
    if (last_out[2] !== 48'd0) begin
      fails++;
      $display("FAIL sync_zero: got %0d, required 0", last_out[2]);
    end
    run_sweep(0, 0, 0, -1);
    tests++;
    if (last_out[2] !== 48'd45812984000) begin
      fails++;
      $display("FAIL sync_inc: got %0d, required 45812984000",
               last_out[2]);
    end
    run_sweep(0, 0, 0, 2);
    run_sweep(0, 0, 0, -1);
    tests++;
    if (last_out[2] !== 48'd0) begin
      fails++;
      $display("FAIL sync_deferred: got %0d, required 0", last_out[2]);
    end
    @(negedge clk);
    freq_we = 1'b1;
    freq_voice = 3'd4;
    freq_value = 22'd777;
    minc[4] = (64'd777 * CK) & MASK;
    sync_we = 1'b1;
    sync_voice = 3'd4;
    msync[4] = 1'b1;
    @(negedge clk);
    freq_we = 1'b0;
    sync_we = 1'b0;
    run_sweep(25, 0, 0, -1);
    run_sweep(25, 0, 0, -1);
  endtask

  task automatic test_enable();
    do_reset();
    for (int i = 0; i < VOICES; i++)
      write_freq(i, 64'($urandom_range(4194303)));
    run_sweep(0, 0, 0, -1);
    voice_enable = 8'hDF;
    for (int s = 0; s < 3; s++) run_sweep(30, 0, 0, -1);
    voice_enable = '1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < VOICES; i++)
      write_freq(i, 64'($urandom_range(4194303)));
    run_sweep(0, 0, 0, -1);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: valid=%b busy=%b, required 0 0",
               out_valid, busy);
    end
    reset = 1'b0;
    model_clear();
    run_sweep(0, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        int vi;
        longint unsigned f;
        vi = $urandom_range(VOICES - 1);
        f = 64'($urandom_range(4194303));
        @(negedge clk);
        freq_we = 1'b1;
        freq_voice = VW'(vi);
        freq_value = 22'(f);
        minc[vi] = (f * CK) & MASK;
      end
      @(negedge clk);
      freq_we = 1'b0;
      if ($urandom_range(1) == 1) sync_pulse($urandom_range(VOICES - 1));
      voice_enable = VOICES'($urandom());
      run_sweep(30, 0, 0, $urandom_range(1) == 1 ?
                int'($urandom_range(VOICES - 1)) : -1);
    end
    voice_enable = '1;
    run_sweep(0, 0, 0, -1);
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL random_overrun: overrun=%b, required 0", overrun);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_440();
    test_wrap();
    test_stall_overrun();
    test_sync();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
